// File: rtl/bit_stream_tx_if.sv
// bit_stream_tx_if
// Word handshake between a data producer and bit_stream_tx.
//   data_in    : word to transmit (DATA_W bits), driven by the producer
//   data_valid : producer has a word on data_in
//   data_ready : transmitter takes data_in on this cycle's rising edge
// Modports: master = producer side, slave = transmitter side.
`timescale 1ns/1ps

interface bit_stream_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/bit_stream_tx.sv
// bit_stream_tx
// Serialises parallel words onto a single line. Each frame starts with an
// alternating 1,0,1,0... preamble of PRE_LEN bits. The preamble is followed
// by one or more DATA_W-bit words, each sent MSB first. Every bit lasts P
// clk_200M cycles. P is latched from bit_period when the frame starts, with
// a minimum of 2.
// Ports:
//   clk_200M    : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bit_period  : requested cycles per bit (16 bits)
//   bus         : slave side of bit_stream_tx_if (data_in/data_valid/data_ready)
//   signal_o    : registered serial output
//   busy        : high whenever a frame is in progress
//   frame_done  : one-cycle pulse on the first idle cycle after a frame
// Configuration macro MANCHESTER_EN: when defined, every bit is Manchester
// encoded. A 0 is sent high then low, and a 1 is sent low then high. P is
// also rounded down to even. When the macro is undefined, the line is NRZ.
`timescale 1ns/1ps

module bit_stream_tx #(
  parameter int PRE_LEN = 8,
  parameter int DATA_W  = 8
) (
  input  logic                clk_200M,
  input  logic                rst_n,
  input  logic [15:0]         bit_period,
  bit_stream_tx_if.slave      bus,
  output logic                signal_o,
  output logic                busy,
  output logic                frame_done
);

  localparam int MAX_BITS = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PRE_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t            state, nxt_state;
  logic [15:0]       period_q, nxt_period;
  logic [15:0]       cyc_cnt, nxt_cyc;
  logic [BIT_W-1:0]  bit_cnt, nxt_bit;
  logic [DATA_W-1:0] shift_q, nxt_shift;
  logic              nxt_sig, nxt_done, nxt_bit_val;
  logic              ready_en;
  logic              ready_int;
  logic              transfer;
  logic              bit_end;
  logic [15:0]       period_eff;

  // Period captured at the start of a frame. It is clamped to 2 so that a
  // Manchester bit always has two non-empty halves.
  always_comb begin
    period_eff = (bit_period < 16'd2) ? 16'd2 : bit_period;
`ifdef MANCHESTER_EN
    period_eff[0] = 1'b0;
`endif
  end

  assign bit_end  = (cyc_cnt == (period_q - 16'd1));
  assign transfer = bus.data_valid & ready_int;
  assign busy     = (state != IDLE);

  // ready_en keeps data_ready low until the first edge after reset is released.
  // In DATA, data_ready is high only on the last cycle of the LSB. This allows
  // the next word to follow with no gap.
  assign ready_int = ready_en &
                     ((state == IDLE) ||
                      ((state == DATA) && (bit_cnt == DATA_LAST) && bit_end));
  assign bus.data_ready = ready_int;

  // Next-state logic. signal_o is a register, so the line value for the next
  // cycle is computed from the next-state values rather than the current ones.
  always_comb begin
    nxt_state   = state;
    nxt_period  = period_q;
    nxt_cyc     = cyc_cnt;
    nxt_bit     = bit_cnt;
    nxt_shift   = shift_q;
    nxt_done    = 1'b0;
    nxt_bit_val = 1'b0;
    nxt_sig     = 1'b0;

    case (state)
      IDLE: begin
        if (transfer) begin
          nxt_state  = PRE;
          nxt_period = period_eff;
          nxt_cyc    = '0;
          nxt_bit    = '0;
          nxt_shift  = bus.data_in;
        end
      end
      PRE: begin
        if (bit_end) begin
          nxt_cyc = '0;
          if (bit_cnt == PRE_LAST) begin
            nxt_state = DATA;
            nxt_bit   = '0;
          end else begin
            nxt_bit = bit_cnt + 1'b1;
          end
        end else begin
          nxt_cyc = cyc_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          nxt_cyc = '0;
          if (bit_cnt == DATA_LAST) begin
            nxt_bit = '0;
            if (transfer) begin
              nxt_shift = bus.data_in;
            end else begin
              nxt_state  = IDLE;
              nxt_shift  = '0;
              nxt_period = '0;
              nxt_done   = 1'b1;
            end
          end else begin
            nxt_bit   = bit_cnt + 1'b1;
            nxt_shift = shift_q << 1;
          end
        end else begin
          nxt_cyc = cyc_cnt + 16'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    case (nxt_state)
      PRE:     nxt_bit_val = ~nxt_bit[0];
      DATA:    nxt_bit_val = nxt_shift[DATA_W-1];
      default: nxt_bit_val = 1'b0;
    endcase

`ifdef MANCHESTER_EN
    if (nxt_state != IDLE)
      nxt_sig = (nxt_cyc < (nxt_period >> 1)) ? ~nxt_bit_val : nxt_bit_val;
`else
    nxt_sig = nxt_bit_val;
`endif
  end

  // State and output registers. Reset clears everything immediately, which
  // aborts any frame in progress without producing a frame_done pulse.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_q   <= '0;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      signal_o   <= 1'b0;
      frame_done <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= nxt_state;
      period_q   <= nxt_period;
      cyc_cnt    <= nxt_cyc;
      bit_cnt    <= nxt_bit;
      shift_q    <= nxt_shift;
      signal_o   <= nxt_sig;
      frame_done <= nxt_done;
      ready_en   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_stream_tx.sv
// tb_bit_stream_tx
// Self-checking bench for bit_stream_tx using a scoreboard. When a frame is
// driven, the bench builds the expected per-cycle values of signal_o, busy,
// frame_done and data_ready and pushes them to a queue. A monitor pops one
// entry on every falling clock edge. When the queue is empty, the monitor
// expects the idle values instead. The model follows MANCHESTER_EN so that
// both builds can be checked.
`timescale 1ns/1ps

module tb_bit_stream_tx;

  localparam int PRE_LEN = 8;
  localparam int DATA_W  = 8;

  typedef struct packed {
    logic sig;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic        clk_200M;
  logic        rst_n;
  logic [15:0] bit_period;
  logic        signal_o;
  logic        busy;
  logic        frame_done;

  bit_stream_tx_if #(.DATA_W(DATA_W)) bus ();

  bit_stream_tx #(.PRE_LEN(PRE_LEN), .DATA_W(DATA_W)) dut (
    .clk_200M   (clk_200M),
    .rst_n      (rst_n),
    .bit_period (bit_period),
    .bus        (bus),
    .signal_o   (signal_o),
    .busy       (busy),
    .frame_done (frame_done)
  );

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;

  initial clk_200M = 1'b0;
  always #2.5 clk_200M = ~clk_200M;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic b, input logic d, input logic r);
    exp_t e;
    e.sig   = s;
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    return e;
  endfunction

  function automatic int effPeriod(input int bp);
    int p;
    p = (bp < 2) ? 2 : bp;
`ifdef MANCHESTER_EN
    p = p - (p % 2);
`endif
    return p;
  endfunction

  function automatic logic enc(input logic b, input int c, input int p);
`ifdef MANCHESTER_EN
    return (c < p / 2) ? ~b : b;
`else
    return b;
`endif
  endfunction

  // Expected line activity for one frame. The transfer cycle itself is left
  // out when it coincides with the previous frame's frame_done entry.
  task automatic pushFrame(input logic [2:0][7:0] w, input int nw, input int p, input bit on_done);
    if (!on_done) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < PRE_LEN; i++)
      for (int c = 0; c < p; c++)
        exp_q.push_back(mk(enc((i % 2) == 0, c, p), 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < nw; k++)
      for (int j = DATA_W - 1; j >= 0; j--)
        for (int c = 0; c < p; c++)
          exp_q.push_back(mk(enc(w[k][j], c, p), 1'b1, 1'b0, (j == 0) && (c == p - 1)));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  // Drives one frame, starting at the beginning of the transfer cycle. Each
  // following word is held on data_in until its known acceptance cycle.
  task automatic applyStimulus(input logic [2:0][7:0] w, input int nw, input int bp,
                               input bit on_done, input bit change_bp);
    int p;
    p = effPeriod(bp);
    pushFrame(w, nw, p, on_done);
    bit_period     = 16'(bp);
    bus.data_in    = w[0];
    bus.data_valid = 1'b1;
    @(posedge clk_200M); #1;
    if (change_bp) bit_period = 16'd10;
    for (int k = 1; k < nw; k++) begin
      bus.data_in = w[k];
      repeat ((k == 1) ? p * (PRE_LEN + DATA_W) : p * DATA_W) @(posedge clk_200M);
      #1;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic waitDrain(input int leave);
    int guard;
    guard = 0;
    while (exp_q.size() > leave && guard < 5000) begin
      @(posedge clk_200M); #1;
      guard++;
    end
    if (exp_q.size() > leave) begin
      checkOutput("drain_timeout", 32'(exp_q.size()), 32'(leave));
      exp_q.delete();
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk_200M);
    #1;
  endtask

  // Monitor: compares one scoreboard entry per cycle, or the idle values
  // when no frame is expected.
  always @(negedge clk_200M) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("signal_o", 32'(signal_o), 32'(e.sig));
      checkOutput("busy", 32'(busy), 32'(e.busy));
      checkOutput("frame_done", 32'(frame_done), 32'(e.done));
      checkOutput("data_ready", 32'(bus.data_ready), 32'(e.ready));
    end
  end

  // Test sequence.
  initial begin
    logic [2:0][7:0] w;
    int nw;
    int bp;

    rst_n          = 1'b0;
    bit_period     = 16'd4;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    repeat (2) @(posedge clk_200M); #1;
    checkOutput("rst_signal_o", 32'(signal_o), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_data_ready", 32'(bus.data_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", 32'(bus.data_ready), 32'd0);
    @(posedge clk_200M); #1;
    mon_en = 1'b1;

    $display("[TB] single word 0xA5, bit_period 4");
    w = {8'h00, 8'h00, 8'hA5};
    applyStimulus(w, 1, 4, 1'b0, 1'b0);
    waitDrain(0);
    idleCycles(3);

    $display("[TB] back-to-back 0xFF, 0x00, bit_period 3");
    w = {8'h00, 8'h00, 8'hFF};
    applyStimulus(w, 2, 3, 1'b0, 1'b0);
    waitDrain(0);
    idleCycles(2);

    $display("[TB] bit_period 0 and 1, change to 10 mid-frame");
    w = {8'h00, 8'h00, 8'h3C};
    applyStimulus(w, 1, 0, 1'b0, 1'b0);
    waitDrain(0);
    idleCycles(1);
    w = {8'h00, 8'h00, 8'h5A};
    applyStimulus(w, 1, 1, 1'b0, 1'b1);
    waitDrain(0);
    idleCycles(2);

    $display("[TB] Manchester-style word 0x01, bit_period 4");
    w = {8'h00, 8'h00, 8'h01};
    applyStimulus(w, 1, 4, 1'b0, 1'b0);
    waitDrain(0);
    idleCycles(1);

    $display("[TB] new transfer on the frame_done cycle");
    w = {8'h00, 8'h00, 8'h81};
    applyStimulus(w, 1, 2, 1'b0, 1'b0);
    waitDrain(1);
    w = {8'h00, 8'h00, 8'h7E};
    applyStimulus(w, 1, 5, 1'b1, 1'b0);
    waitDrain(0);
    idleCycles(2);

    $display("[TB] reset in the middle of a frame");
    w = {8'h00, 8'h00, 8'hC3};
    applyStimulus(w, 1, 4, 1'b0, 1'b0);
    repeat (19) @(posedge clk_200M);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_signal_o", 32'(signal_o), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_data_ready", 32'(bus.data_ready), 32'd0);
    checkOutput("abort_frame_done", 32'(frame_done), 32'd0);
    repeat (2) begin
      @(negedge clk_200M);
      checkOutput("abort_hold_done", 32'(frame_done), 32'd0);
    end
    @(posedge clk_200M); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("abort_ready_release", 32'(bus.data_ready), 32'd0);
    @(posedge clk_200M); #1;
    mon_en = 1'b1;
    w = {8'h00, 8'h00, 8'h96};
    applyStimulus(w, 1, 4, 1'b0, 1'b0);
    waitDrain(0);
    idleCycles(2);

    $display("[TB] random frames");
    for (int r = 0; r < 4; r++) begin
      nw = int'($urandom_range(1, 3));
      bp = int'($urandom_range(0, 6));
      w  = {8'($urandom), 8'($urandom), 8'($urandom)};
      applyStimulus(w, nw, bp, 1'b0, 1'b0);
      waitDrain(0);
      idleCycles(int'($urandom_range(0, 2)));
    end

    idleCycles(2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bit_stream_tx.md
BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 Parameter PRE_LEN, default 8, number of alternating preamble bits sent before each frame (range 2..255).
REQ-002 Parameter DATA_W, default 8, width of each parallel data word.
REQ-003 clk_200M  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bit_period  input  16  clk_200M cycles per transmitted bit.
REQ-006 data_in  input  DATA_W  word to transmit.
REQ-007 data_valid  input  1  data_in is valid.
REQ-008 data_ready  output  1  block accepts data_in this cycle.
REQ-009 signal_o  output  1  serial line output, registered.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-012 Transfer occurs on any cycle with data_valid and data_ready both high; data_in is sampled into a shift register on that edge.
REQ-013 States: IDLE, PRE, DATA. Transitions: IDLE->PRE on transfer; PRE->DATA after PRE_LEN bits; DATA->DATA on transfer at word end; DATA->IDLE at word end without transfer.
REQ-014 The effective period P is latched on the IDLE transfer edge: P = bit_period, or 2 if bit_period < 2; P is held constant for the whole frame.
REQ-015 Each bit occupies exactly P consecutive cycles of signal_o; the first preamble bit starts on the cycle after the IDLE transfer.
REQ-016 Preamble pattern: 1,0,1,0,... starting with 1, PRE_LEN bits total.
REQ-017 DATA sends the word MSB first, DATA_W bits, with no gap after the preamble.
REQ-018 data_ready: high in IDLE; in DATA, high only on the final cycle of the last (LSB) bit of the current word; low in PRE and at all other times.
REQ-019 A transfer on that final DATA cycle makes the next word's MSB begin on the following cycle (back-to-back, no idle cycle, no preamble).
REQ-020 DATA->IDLE: signal_o = 0 from the first IDLE cycle; frame_done = 1 for exactly that cycle.
REQ-021 signal_o is 0 throughout IDLE.
REQ-022 The bit-cycle counter is 16 bits and counts 0..P-1, then wraps to 0; it never exceeds P-1.
REQ-023 Changes of bit_period during PRE or DATA have no effect until the next frame.
REQ-024 In IDLE, data_valid high on the same cycle frame_done pulses is a legal transfer and starts a new preamble on the next cycle.

Reset
REQ-025 While rst_n is low: state = IDLE, signal_o = 0, busy = 0, frame_done = 0, data_ready = 0, and all counters and shift register = 0.
REQ-026 Reset asserted mid-frame aborts immediately: signal_o goes low asynchronously and no frame_done is generated.
REQ-027 data_ready may first rise on the first clk_200M edge after rst_n deasserts.

Configuration
REQ-028 Macro MANCHESTER_EN: when defined, each bit is Manchester-encoded (IEEE 802.3): 0 = high for the first half, low for the second; 1 = low then high; preamble bits are encoded the same way.
REQ-029 With MANCHESTER_EN, the half-period is P>>1 cycles and P is rounded down to even (minimum 2); the first half occupies cycles 0..P/2-1 of the bit.
REQ-030 Without MANCHESTER_EN, the output is NRZ: signal_o equals the bit value for all P cycles.
REQ-031 With MANCHESTER_EN, timing of data_ready, busy and frame_done is identical to NRZ for the same P.

Verification
REQ-032 NRZ, bit_period=4, PRE_LEN=8, single word 0xA5 transferred at cycle T -> signal_o 1 on T+1..T+4, 0 on T+5..T+8 and so on; data starts at T+33 with the pattern 1,0,1,0,0,1,0,1 at 4 cycles each; frame_done=1 at T+65 only.
REQ-033 Two words 0xFF, 0x00 with data_valid held high, bit_period=3 -> data_ready pulses at the last cycle of word 1; signal_o is high 24 cycles, then low 24 cycles with no gap; a single frame_done.
REQ-034 bit_period=0 and bit_period=1 -> each bit lasts 2 cycles; bit_period changed to 10 mid-frame -> frame timing unchanged.
REQ-035 rst_n pulled low at cycle T+20 of a frame -> signal_o=0, busy=0, data_ready=0 immediately; no frame_done; a new transfer after release starts a fresh preamble.
REQ-036 MANCHESTER_EN, bit_period=4, word 0x01 -> each 0 bit = 1,1,0,0 and the final 1 bit = 0,0,1,1; frame_done cycle matches NRZ.
REQ-037 New transfer on the frame_done cycle -> preamble begins on the next cycle, with busy staying low for exactly one cycle.
